// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect request and the
// decode-facing instruction handshake, with run/halted control.
interface fetch_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     run;
    logic [ADDRESS_WIDTH-1:0] imem_a;
    logic [DATA_WIDTH-1:0]    imem_rd;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     halted;

    // The fetch sequencer drives the memory address and the decode-facing stream.
    modport master (
        input  run, imem_rd, redirect_valid, redirect_pc, instr_ready,
        output imem_a, instr_valid, instr, instr_pc, halted
    );

    modport slave (
        output run, imem_rd, redirect_valid, redirect_pc, instr_ready,
        input  imem_a, instr_valid, instr, instr_pc, halted
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: PC register, IDLE/RUN/HALTED control and a
// 2-entry {pc, instr} queue feeding decode, with branch redirect and ebreak halt.
module fetch_seq #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [DATA_WIDTH-1:0]    EBREAK  = DATA_WIDTH'(32'h0010_0073);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    state_t                   state;
    logic                     halted_q;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [1:0]               count;
    logic                     rd_ptr;
    logic                     wr_ptr;

    logic [ADDRESS_WIDTH-1:0] pc_mem    [2];
    logic [DATA_WIDTH-1:0]    instr_mem [2];

    logic pop;
    logic push;

    // NOTE: combinational logic uses blocking '=' so later lines see the values computed above them.
    always_comb begin
        pop  = (count != 2'd0) && bus.instr_ready && !bus.redirect_valid;
        push = (state == RUN) && !bus.redirect_valid && ((count < 2'd2) || pop);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            halted_q <= 1'b0;
            pc       <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect flushes the queue and overrides any push/pop this cycle.
            pc     <= {bus.redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            if (state == HALTED || bus.run) begin
                state    <= RUN;
                halted_q <= 1'b0;
            end
        end else begin
            if (push) begin
                pc     <= pc + PC_STEP;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The ebreak itself is queued; fetching stops after it.
                    if (push && bus.imem_rd == EBREAK) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // NOTE: queue storage has no reset; validity comes solely from count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= bus.imem_rd;
        end
    end

    assign bus.imem_a      = pc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = instr_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];
    assign bus.halted      = halted_q;
endmodule
